// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: default fetch parameters and fetch state type
package fetch_unit_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam logic [31:0] DEF_INIT_PC = 32'h0000_0000;
    localparam int DEF_INST_BYTES = 4;
    localparam int DEF_DEPTH = 4;
    typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and ID-side signals of the fetch unit
interface fetch_unit_if #(parameter int ADDR_W = 32);
    logic flush;
    logic [ADDR_W-1:0] exc_pc;
    logic branch_flag;
    logic [ADDR_W-1:0] branch_addr;
    logic stall;
    logic req_valid;
    logic req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic resp_valid;
    logic [ADDR_W-1:0] resp_data;
    logic out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_inst;
    logic out_misalign;
    modport master (
        input  flush, exc_pc, branch_flag, branch_addr, stall, req_ready, resp_valid, resp_data,
        output req_valid, req_addr, out_valid, out_pc, out_inst, out_misalign
    );
    modport slave (
        output flush, exc_pc, branch_flag, branch_addr, stall, req_ready, resp_valid, resp_data,
        input  req_valid, req_addr, out_valid, out_pc, out_inst, out_misalign
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order circular buffer of {pc, inst, data_valid, misalign} fetch entries
module fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic push_misalign,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic fill,
    input  logic [ADDR_W-1:0] fill_data,
    input  logic pop,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] pending,
    output logic head_ready,
    output logic [ADDR_W-1:0] head_pc,
    output logic [ADDR_W-1:0] head_inst,
    output logic head_misalign
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0] rd, wr, fl;
    logic [PW-1:0] push_idx;
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [ADDR_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0] ready_q, mis_q;
    // a clearing push becomes the sole entry at slot 0; misaligned pushes only ever arrive with clear
    assign push_idx = clear ? '0 : wr[PW-1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= '0;
            wr <= '0;
            fl <= '0;
            ready_q <= '0;
            mis_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            if (push) begin
                pc_q[push_idx] <= push_pc;
                inst_q[push_idx] <= '0;
                ready_q[push_idx] <= push_misalign;
                mis_q[push_idx] <= push_misalign;
            end
            if (fill && !clear) begin
                inst_q[fl[PW-1:0]] <= fill_data;
                ready_q[fl[PW-1:0]] <= 1'b1;
            end
            rd <= clear ? '0 : rd + (PW+1)'(pop);
            wr <= clear ? (PW+1)'(push) : wr + (PW+1)'(push);
            fl <= clear ? (PW+1)'(push & push_misalign) : fl + (PW+1)'(fill);
        end
    end
    assign count = wr - rd;
    assign pending = wr - fl;
    assign head_ready = (count != '0) && ready_q[rd[PW-1:0]];
    assign head_pc = pc_q[rd[PW-1:0]];
    assign head_inst = inst_q[rd[PW-1:0]];
    assign head_misalign = mis_q[rd[PW-1:0]];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage front end issuing pipelined fetches, buffering responses and applying redirects
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] INIT_PC = ADDR_W'(DEF_INIT_PC),
    parameter int INST_BYTES = DEF_INST_BYTES,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic clk,
    input logic rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    fetch_state_e state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, pc_nx, target;
    logic [CW-1:0] drop_cnt, drop_nx, count, pending;
    logic [CW:0] used;
    logic redir, mis, issue, resp_old, fill, pop, head_ready;
    assign redir = bus.flush | bus.branch_flag;
    assign target = bus.flush ? bus.exc_pc : bus.branch_addr;
    assign mis = redir && (target & ALIGN_MASK) != '0;
    assign used = {1'b0, count} + {1'b0, drop_cnt};
    assign bus.req_valid = (used < DEPTH_C) && !mis && (redir || state == RUN);
    assign bus.req_addr = redir ? target : fetch_pc;
    assign issue = bus.req_valid & bus.req_ready;
    // a response owed to the old stream: already counted as dropped, or filling a pending entry being killed
    assign resp_old = bus.resp_valid && (drop_cnt != '0 || (redir && pending != '0));
    assign fill = bus.resp_valid && drop_cnt == '0 && pending != '0 && !redir;
    assign bus.out_valid = head_ready & !redir;
    assign pop = bus.out_valid & !bus.stall;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fetch_pc <= INIT_PC;
            drop_cnt <= '0;
        end else begin
            state <= state_nx;
            fetch_pc <= pc_nx;
            drop_cnt <= drop_nx;
        end
    end
    always_comb begin
        state_nx = redir ? (mis ? HALT : RUN) : state;
        pc_nx = issue ? bus.req_addr + ADDR_W'(INST_BYTES) : (redir ? target : fetch_pc);
        drop_nx = drop_cnt + (redir ? pending : '0) - CW'(resp_old);
    end
    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_queue (
        .clk(clk),
        .rst(rst),
        .clear(redir),
        .push(issue | mis),
        .push_misalign(mis),
        .push_pc(bus.req_addr),
        .fill(fill),
        .fill_data(bus.resp_data),
        .pop(pop),
        .count(count),
        .pending(pending),
        .head_ready(head_ready),
        .head_pc(bus.out_pc),
        .head_inst(bus.out_inst),
        .head_misalign(bus.out_misalign)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic checked against a queue-level reference model
module tb_fetch_unit;
    localparam int AW = 32;
    localparam logic [31:0] IPC = 32'h8000_0000;
    localparam int DEPTH = 4;
    typedef struct {logic [31:0] pc; bit ready; bit mis;} ent_t;
    typedef struct {int due; logic [31:0] data;} mem_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_unit_if #(.ADDR_W(AW)) bus();
    fetch_unit #(.ADDR_W(AW), .INIT_PC(IPC), .INST_BYTES(4), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    ent_t q[$];
    mem_t mq[$];
    logic [31:0] exp_pc;
    bit halted;
    int owed, cyc, lat, checks, errors;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mq.delete();
        exp_pc = IPC;
        halted = 0;
        owed = 0;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.exc_pc = '0; bus.branch_flag = 0; bus.branch_addr = '0;
        bus.stall = 0; bus.req_ready = 1; bus.resp_valid = 0; bus.resp_data = '0;
    endtask

    // one clock cycle: drive, check combinational outputs, advance the model
    task automatic tick(bit fl, logic [31:0] ea, bit br, logic [31:0] ba, bit st, bit rdy);
        bit redir, mis, rv, ov, issue, done;
        logic [31:0] tgt, addr;
        bus.flush = fl; bus.exc_pc = ea; bus.branch_flag = br; bus.branch_addr = ba;
        bus.stall = st; bus.req_ready = rdy;
        bus.resp_valid = mq.size() > 0 && mq[0].due <= cyc;
        bus.resp_data = bus.resp_valid ? mq[0].data : $urandom();
        #1;
        redir = fl | br;
        tgt = fl ? ea : ba;
        mis = redir && tgt[1:0] != 2'b00;
        rv = !mis && (redir || !halted) && (q.size() + owed < DEPTH);
        addr = redir ? tgt : exp_pc;
        ov = !redir && q.size() > 0 && q[0].ready;
        chk("req_valid", bus.req_valid, rv);
        if (rv) chk("req_addr", bus.req_addr, addr);
        chk("out_valid", bus.out_valid, ov);
        if (ov) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_inst", bus.out_inst, q[0].mis ? 32'h0 : memfn(q[0].pc));
            chk("out_misalign", bus.out_misalign, q[0].mis);
        end
        issue = rv && rdy;
        if (ov && !st) q.delete(0);
        if (bus.resp_valid) begin
            mq.delete(0);
            done = 0;
            if (owed > 0) owed--;
            else for (int i = 0; i < q.size(); i++)
                if (!q[i].ready && !done) begin q[i].ready = 1; done = 1; end
        end
        if (redir) begin
            for (int i = 0; i < q.size(); i++) if (!q[i].ready) owed++;
            q.delete();
        end
        if (issue) begin
            mq.push_back('{cyc + lat, memfn(addr)});
            q.push_back('{addr, 1'b0, 1'b0});
            exp_pc = addr + 32'd4;
        end
        if (mis) begin
            q.push_back('{tgt, 1'b1, 1'b1});
            halted = 1;
            exp_pc = tgt;
        end else if (redir) begin
            halted = 0;
            if (!issue) exp_pc = tgt;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(int n, bit st);
        for (int i = 0; i < n; i++) tick(0, '0, 0, '0, st, 1);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : 32'h8000_0000 + ($urandom_range(0, 255) << 2);
        return ($urandom_range(0, 3) == 0) ? t + 32'd2 : t;
    endfunction

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        chk("rst_req_valid", bus.req_valid, 1);
        chk("rst_req_addr", bus.req_addr, IPC);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_inst", bus.out_inst, 0);
        chk("rst_out_misalign", bus.out_misalign, 0);
        rst = 0;
        // streaming at k=1: first instruction two cycles after its request
        run(2, 0);
        chk("first_out_valid", bus.out_valid, 1);
        chk("first_out_pc", bus.out_pc, IPC);
        run(10, 0);
        // stall fills the queue, then releases
        run(6, 1);
        run(6, 0);
        // branch with responses in flight at k=2
        lat = 2;
        run(3, 0);
        tick(0, '0, 1, 32'h8000_0100, 0, 1);
        run(8, 0);
        // flush beats a simultaneous branch
        tick(1, 32'h8000_0180, 1, 32'h8000_0100, 0, 1);
        run(6, 0);
        // redirect while a k=1 response lands in the same cycle
        lat = 1;
        run(3, 0);
        tick(0, '0, 1, 32'h8000_0200, 0, 1);
        run(5, 0);
        // misaligned target halts fetch until a flush restarts it
        tick(0, '0, 1, 32'h8000_0102, 0, 1);
        run(5, 1);
        run(2, 0);
        tick(1, 32'h8000_0180, 0, '0, 0, 1);
        run(5, 0);
        // PC wrap
        tick(1, 32'hFFFF_FFFC, 0, '0, 0, 1);
        run(5, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            tick($urandom_range(0, 15) == 0, rand_target(), $urandom_range(0, 9) == 0, rand_target(),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        // asynchronous reset mid-operation
        idle_inputs();
        rst = 1;
        #1;
        chk("arst_req_valid", bus.req_valid, 1);
        chk("arst_req_addr", bus.req_addr, IPC);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_pc", bus.out_pc, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            lat = $urandom_range(1, 3);
            tick($urandom_range(0, 19) == 0, rand_target(), $urandom_range(0, 9) == 0, rand_target(),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
        end
        tick(1, 32'h8000_0040, 0, '0, 0, 1);
        run(20, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
